// File: rtl/snicker_axi_pkg.sv
// AXI4-Lite definitions shared by the snickerbits memory path.
package snicker_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } axil_ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axil_r_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags; push while full is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk_axi,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             r_full;
    logic             r_empty;
    logic             w_wr;
    logic             w_rd;
    logic [AW:0]      w_cnt_nxt;

    assign w_rd      = i_pop && !r_empty;
    assign w_wr      = i_push && (!r_full || w_rd);
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);

    always_ff @(posedge clk_axi) begin
        if (w_wr)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr)
                r_wr <= r_wr + AW'(1);
            if (w_rd)
                r_rd <= r_rd + AW'(1);
            r_cnt   <= w_cnt_nxt;
            r_full  <= w_cnt_nxt == (AW+1)'(DEPTH);
            r_empty <= w_cnt_nxt == '0;
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/sha256_mem_reader.sv
// Turns sha256 fire-and-forget word reads into AXI4-Lite reads,
// queueing requests and capping reads in flight.
module sha256_mem_reader
    import snicker_axi_pkg::*;
#(
    parameter int REQ_DEPTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk_axi,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_addr_vld,
    input  logic [31:0]       mem_addr,
    output logic              mem_data_vld,
    output logic [31:0]       mem_data,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_resp
);

    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_bypass;
    logic              w_can_load;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic [3:0]        w_outst_nxt;
    logic              w_unused_lsb;
    axil_r_t           w_r;

    logic [3:0]        r_outst;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_mdv;
    logic [31:0]       r_md;
    logic              r_ovf;
    logic              r_rerr;

    assign w_unused_lsb = ^mem_addr[1:0];
    assign w_req_addr   = base_addr + ADDR_W'({mem_addr[31:2], 2'b00});
    assign w_r          = '{data: m_axi_rdata, resp: m_axi_rresp};

    // A beat with nothing outstanding is a slave fault; drop it.
    assign w_ar_hs     = r_arvalid && m_axi_arready;
    assign w_r_hs      = m_axi_rvalid && m_axi_rready && (r_outst != 4'd0);
    assign w_outst_nxt = r_outst + {3'b000, w_ar_hs} - {3'b000, w_r_hs};

    // The loaded AR counts against the cap from the cycle it is pending.
    assign w_can_load = (!r_arvalid || w_ar_hs) && (w_outst_nxt < MAX_OS);
    assign w_pop      = w_can_load && !w_empty;
    assign w_bypass   = w_can_load && w_empty && mem_addr_vld;
    assign w_push     = mem_addr_vld && !w_bypass;

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk_axi (clk_axi),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_req_addr),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            r_outst   <= 4'd0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_mdv     <= 1'b0;
            r_md      <= 32'd0;
            r_ovf     <= 1'b0;
            r_rerr    <= 1'b0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_ar_hs)
                r_arvalid <= 1'b0;
            if (w_pop) begin
                r_arvalid <= 1'b1;
                r_araddr  <= w_head;
            end else if (w_bypass) begin
                r_arvalid <= 1'b1;
                r_araddr  <= w_req_addr;
            end
            r_mdv <= w_r_hs;
            if (w_r_hs)
                r_md <= w_r.data;
            if (mem_addr_vld && w_full && !w_pop)
                r_ovf <= 1'b1;
            if (w_r_hs && resp_is_err(w_r.resp))
                r_rerr <= 1'b1;
        end
    end

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = ARPROT_DEFAULT;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = !rst;
    assign mem_data_vld  = r_mdv;
    assign mem_data      = r_md;
    assign err_overflow  = r_ovf;
    assign err_resp      = r_rerr;
    assign busy = !w_empty || (r_outst != 4'd0) || r_arvalid || r_mdv;

endmodule

// File: tb/tb_sha256_mem_reader.sv
// Bench: two readers (cap 4 and cap 1) share one request stream,
// each behind its own in-order AXI-Lite slave with random latency.
module tb_sha256_mem_reader;

    logic        clk;
    logic        rst;
    logic [31:0] base_addr;
    logic        mem_addr_vld;
    logic [31:0] mem_addr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_req = 0;

    int          lat_lo = 1;
    int          lat_hi = 1;
    int          ar_mode = 1;
    bit          err_mode = 0;
    bit          force_en = 0;
    logic [31:0] force_val = 32'd0;
    logic [31:0] salt = 32'd0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];

    logic [1:0] busy_a;
    logic [1:0] ovf_a;
    logic [1:0] err_a;
    logic [1:0] quiet_a;
    logic [1:0] rrdy_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sdata(input logic [31:0] a);
        return force_en ? force_val : ((a * 32'h9E37_79B1) ^ salt);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gs
        localparam int MO = (g == 0) ? 4 : 1;

        logic        mdv, av, ary, rv, rrdy, bsy, eo, er;
        logic [31:0] md, aa, rd;
        logic [2:0]  ap;
        logic [1:0]  rr;

        sha256_mem_reader #(
            .REQ_DEPTH       (8),
            .MAX_OUTSTANDING (MO),
            .ADDR_W          (32)
        ) dut (
            .clk_axi       (clk),
            .rst           (rst),
            .base_addr     (base_addr),
            .mem_addr_vld  (mem_addr_vld),
            .mem_addr      (mem_addr),
            .mem_data_vld  (mdv),
            .mem_data      (md),
            .m_axi_araddr  (aa),
            .m_axi_arprot  (ap),
            .m_axi_arvalid (av),
            .m_axi_arready (ary),
            .m_axi_rdata   (rd),
            .m_axi_rresp   (rr),
            .m_axi_rvalid  (rv),
            .m_axi_rready  (rrdy),
            .busy          (bsy),
            .err_overflow  (eo),
            .err_resp      (er)
        );

        assign busy_a[g]  = bsy;
        assign ovf_a[g]   = eo;
        assign err_a[g]   = er;
        assign rrdy_a[g]  = rrdy;
        assign quiet_a[g] = !(mdv || (|md) || (|aa) || av || (|ap) ||
                              rrdy || bsy || eo || er);

        logic [31:0] sq_a[$];
        int          sq_due[$];
        int          ar_i = 0;
        int          dat_i = 0;
        int          beats = 0;
        int          max_out = 0;
        int          viol = 0;
        int          last_beat = 0;
        logic [31:0] last_ar = 32'd0;
        logic [31:0] last_dat = 32'd0;
        logic        pv = 1'b0;
        logic        pr = 1'b0;
        logic [31:0] pa = 32'd0;
        logic        n_ary = 1'b0;
        logic        n_rv = 1'b0;
        logic [31:0] n_rd = 32'd0;
        logic [1:0]  n_rr = 2'b00;

        // Observe the cycle at the falling edge, decide next-cycle drives.
        always @(negedge clk) begin
            if (rst) begin
                sq_a.delete();
                sq_due.delete();
                ar_i  = 0;
                dat_i = 0;
                pv    = 1'b0;
                n_ary = 1'b0;
                n_rv  = 1'b0;
            end else begin
                if (av && sq_a.size() >= MO)
                    viol++;
                if (pv && !pr) begin
                    chk("ar_hold", {31'd0, av}, 32'd1);
                    chk("ar_addr_hold", aa, pa);
                end
                if (rv) begin
                    assert (sq_a.size() != 0);
                    if (rrdy && sq_a.size() != 0) begin
                        void'(sq_a.pop_front());
                        void'(sq_due.pop_front());
                    end
                end
                if (av && ary) begin
                    if (ar_i < exp_a.size())
                        chk("araddr", aa, exp_a[ar_i]);
                    else
                        chk("ar_extra", 32'd1, 32'd0);
                    chk("arprot", {29'd0, ap}, 32'd0);
                    ar_i++;
                    last_ar = aa;
                    sq_a.push_back(aa);
                    sq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
                end
                if (sq_a.size() > max_out)
                    max_out = sq_a.size();
                if (mdv) begin
                    beats++;
                    last_beat = cyc;
                    last_dat  = md;
                    if (dat_i < exp_d.size())
                        chk("rdata", md, exp_d[dat_i]);
                    else
                        chk("beat_extra", 32'd1, 32'd0);
                    dat_i++;
                end
                pv = av;
                pr = ary;
                pa = aa;
                n_ary = (ar_mode == 0) ? 1'b0 :
                        (ar_mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
                n_rv = (sq_a.size() != 0) && (sq_due[0] <= cyc + 1);
                n_rd = n_rv ? sdata(sq_a[0]) : 32'd0;
                n_rr = err_mode ? 2'b10 : 2'b00;
            end
        end

        initial begin
            ary = 1'b0;
            rv  = 1'b0;
            rd  = 32'd0;
            rr  = 2'b00;
            forever begin
                @(posedge clk);
                #1;
                ary = n_ary;
                rv  = n_rv;
                rd  = n_rd;
                rr  = n_rr;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input logic [31:0] b, input logic [31:0] a);
        logic [31:0] e;
        e = b + {a[31:2], 2'b00};
        base_addr    = b;
        mem_addr     = a;
        mem_addr_vld = 1'b1;
        exp_a.push_back(e);
        exp_d.push_back(sdata(e));
        t_req = cyc;
        step(1);
        mem_addr_vld = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = (busy_a == 2'b00) && !mem_addr_vld &&
                 (gs[0].dat_i == exp_d.size()) &&
                 (gs[1].dat_i == exp_d.size());
        end
        chk("idle_tmo", {31'd0, ok}, 32'd1);
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int b1;
        rst          = 1'b1;
        base_addr    = 32'd0;
        mem_addr     = 32'd0;
        mem_addr_vld = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_quiet", {30'd0, quiet_a}, 32'd3);
        step(1);
        rst = 1'b0;
        step(2);
        chk("rready", {30'd0, rrdy_a}, 32'd3);

        // single read, minimum latency
        force_en  = 1'b1;
        force_val = 32'hDEAD_BEEF;
        b0 = gs[0].beats;
        b1 = gs[1].beats;
        req(32'h1000_0000, 32'h0000_0040);
        wait_idle(50);
        chk("t1_addr0", gs[0].last_ar, 32'h1000_0040);
        chk("t1_addr1", gs[1].last_ar, 32'h1000_0040);
        chk("t1_lat0", gs[0].last_beat - t_req, 32'd3);
        chk("t1_lat1", gs[1].last_beat - t_req, 32'd3);
        chk("t1_data0", gs[0].last_dat, 32'hDEAD_BEEF);
        chk("t1_beats0", gs[0].beats - b0, 32'd1);
        chk("t1_beats1", gs[1].beats - b1, 32'd1);
        chk("t1_busy", {30'd0, busy_a}, 32'd0);
        force_en = 1'b0;

        // burst with AR stalls and random latency
        salt    = $urandom;
        lat_lo  = 1;
        lat_hi  = 5;
        ar_mode = 0;
        b0 = gs[0].beats;
        b1 = gs[1].beats;
        for (int i = 0; i < 6; i++) begin
            if (i == 3)
                ar_mode = 2;
            req(32'd0, 32'(i * 4));
        end
        wait_idle(2000);
        ar_mode = 1;
        chk("t2_beats0", gs[0].beats - b0, 32'd6);
        chk("t2_beats1", gs[1].beats - b1, 32'd6);
        chk("t2_maxout0", {31'd0, gs[0].max_out <= 4}, 32'd1);
        chk("t2_ovf", {30'd0, ovf_a}, 32'd0);

        // error response still forwards data
        err_mode  = 1'b1;
        force_en  = 1'b1;
        force_val = 32'h1234_5678;
        lat_lo    = 1;
        lat_hi    = 1;
        req($urandom, $urandom);
        wait_idle(50);
        chk("t3_data0", gs[0].last_dat, 32'h1234_5678);
        chk("t3_data1", gs[1].last_dat, 32'h1234_5678);
        chk("t3_err", {30'd0, err_a}, 32'd3);
        err_mode = 1'b0;
        force_en = 1'b0;
        step(5);
        chk("t3_sticky", {30'd0, err_a}, 32'd3);

        // overflow: 1 pending + 8 queued, 10th request dropped
        ar_mode = 0;
        step(2);
        b0 = gs[0].beats;
        b1 = gs[1].beats;
        for (int i = 0; i < 10; i++)
            req($urandom, $urandom);
        void'(exp_a.pop_back());
        void'(exp_d.pop_back());
        step(1);
        chk("t4_ovf", {30'd0, ovf_a}, 32'd3);
        ar_mode = 1;
        wait_idle(200);
        chk("t4_beats0", gs[0].beats - b0, 32'd9);
        chk("t4_beats1", gs[1].beats - b1, 32'd9);

        // cap of 1: no AR while a read is outstanding
        lat_lo = 4;
        lat_hi = 4;
        b1 = gs[1].beats;
        b0 = gs[1].viol;
        for (int i = 0; i < 3; i++)
            req(32'h2000_0000, 32'(i * 4));
        wait_idle(200);
        chk("t5_viol1", gs[1].viol - b0, 32'd0);
        chk("t5_beats1", gs[1].beats - b1, 32'd3);
        chk("t5_maxout1", {31'd0, gs[1].max_out <= 1}, 32'd1);

        // random traffic, including address wrap
        lat_lo  = 1;
        lat_hi  = 6;
        ar_mode = 2;
        req(32'hFFFF_FFF8, 32'h0000_0013);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1, 0) == 1 &&
                exp_a.size() - gs[0].ar_i < 8 &&
                exp_a.size() - gs[1].ar_i < 8)
                req($urandom, $urandom);
            else
                step(1);
        end
        wait_idle(3000);
        ar_mode = 1;
        chk("t6_viol0", gs[0].viol, 32'd0);
        chk("t6_viol1", gs[1].viol, 32'd0);
        chk("t6_maxout0", {31'd0, gs[0].max_out <= 4}, 32'd1);

        // reset with reads in flight
        lat_lo = 20;
        lat_hi = 20;
        step(2);
        for (int i = 0; i < 5; i++)
            req(32'h3000_0000, 32'(i * 4));
        step(3);
        rst = 1'b1;
        exp_a.delete();
        exp_d.delete();
        step(1);
        @(negedge clk);
        chk("t7_quiet", {30'd0, quiet_a}, 32'd3);
        step(1);
        rst    = 1'b0;
        lat_lo = 1;
        lat_hi = 1;
        step(2);
        b0 = gs[0].beats;
        b1 = gs[1].beats;
        req(32'h4000_0000, 32'h0000_0100);
        wait_idle(100);
        chk("t7_beats0", gs[0].beats - b0, 32'd1);
        chk("t7_beats1", gs[1].beats - b1, 32'd1);
        chk("t7_addr", gs[0].last_ar, 32'h4000_0100);
        chk("t7_flags", {28'd0, ovf_a, err_a}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
